// File: rtl/k007452_div.sv
// 16/16 unsigned restoring divider with an 8-bit register bus.
// Writes to address 5 start or restart a 16-cycle division; results are read back combinationally.
module k007452_div #(
    parameter logic [15:0] ZDIV_Q = 16'hFFFF
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CS,
    input  logic [2:0] AB_L,
    input  logic       WR,
    input  logic       RD,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    output logic       BUSY
);

    logic        wr_prev;
    logic [15:0] dvd_op;
    logic [15:0] dvs_op;
    logic [15:0] wk_q;
    logic [15:0] wk_dvs;
    logic [15:0] wk_rem;
    logic [3:0]  step;
    logic [15:0] quot;
    logic [15:0] rem;
    logic [31:0] step_res;
    logic        wr_take;
    logic        start;

    // One restoring step: returns {next remainder, next dividend/quotient shift register}.
    // The 17-bit trial keeps the compare exact for divisors above 0x7FFF.
    function automatic logic [31:0] div_step(input logic [15:0] r,
                                              input logic [15:0] qd,
                                              input logic [15:0] d);
        logic [16:0] trial;
        logic        qbit;
        trial = {r, qd[15]};
        qbit  = 1'b0;
        if (trial >= {1'b0, d}) begin
            trial = trial - {1'b0, d};
            qbit  = 1'b1;
        end
        return {trial[15:0], qd[14:0], qbit};
    endfunction

    assign wr_take = !CS && !WR && wr_prev;
    assign start   = wr_take && (AB_L == 3'd5);

    always_comb begin
        step_res = div_step(wk_rem, wk_q, wk_dvs);
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            wr_prev <= 1'b1;
            dvd_op  <= '0;
            dvs_op  <= '0;
            wk_q    <= '0;
            wk_dvs  <= '0;
            wk_rem  <= '0;
            step    <= '0;
            quot    <= '0;
            rem     <= '0;
            BUSY    <= 1'b0;
        end else begin
            wr_prev <= WR;
            if (wr_take) begin
                case (AB_L)
                    3'd2:    dvd_op[7:0]  <= DB_IN;
                    3'd3:    dvd_op[15:8] <= DB_IN;
                    3'd4:    dvs_op[7:0]  <= DB_IN;
                    3'd5:    dvs_op[15:8] <= DB_IN;
                    default: ;
                endcase
            end
            // A start always wins over an iteration, which gives abort-and-restart for free.
            if (start) begin
                wk_q   <= dvd_op;
                wk_dvs <= {DB_IN, dvs_op[7:0]};
                wk_rem <= '0;
                step   <= '0;
                BUSY   <= 1'b1;
            end else if (BUSY) begin
                {wk_rem, wk_q} <= step_res;
                step           <= step + 4'd1;
                if (step == 4'd15) begin
                    BUSY <= 1'b0;
                    quot <= (wk_dvs == 16'd0) ? ZDIV_Q : step_res[15:0];
                    rem  <= step_res[31:16];
                end
            end
        end
    end

    always_comb begin
        DB_OUT = 8'h00;
        DB_OE  = 1'b0;
        if (!CS && !RD) begin
            case (AB_L)
                3'd2:    begin DB_OUT = quot[7:0];  DB_OE = 1'b1; end
                3'd3:    begin DB_OUT = quot[15:8]; DB_OE = 1'b1; end
                3'd4:    begin DB_OUT = rem[7:0];   DB_OE = 1'b1; end
                3'd5:    begin DB_OUT = rem[15:8];  DB_OE = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_k007452_div.sv
// Scoreboard bench for k007452_div: stimulus queues expected reads and BUSY lengths,
// monitors on the falling clock edge pop and compare.
module tb_k007452_div;

    logic       CLK = 1'b0;
    logic       RES;
    logic       CS;
    logic [2:0] AB_L;
    logic       WR;
    logic       RD;
    logic [7:0] DB_IN;
    logic [7:0] DB_OUT;
    logic       DB_OE;
    logic       BUSY;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int bcnt   = 0;
    int last_wr_cyc = 0;

    logic [8:0] rd_q[$];
    int         lat_q[$];

    k007452_div #(.ZDIV_Q(16'hFFFF)) dut (
        .CLK(CLK), .RES(RES), .CS(CS), .AB_L(AB_L), .WR(WR), .RD(RD),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Read-bus monitor: every sampled read cycle is matched against the next queued expectation.
    always @(negedge CLK) begin
        if (!CS && !RD) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected addr=%0d got oe=%0b data=%02h", AB_L, DB_OE, DB_OUT);
            end else begin
                logic [8:0] e;
                e = rd_q.pop_front();
                if ({DB_OE, DB_OUT} !== e) begin
                    errors++;
                    $display("FAIL read addr=%0d got oe=%0b data=%02h want oe=%0b data=%02h",
                             AB_L, DB_OE, DB_OUT, e[8], e[7:0]);
                end
            end
        end
    end

    // BUSY-length monitor; a stretch cut short by reset is discarded.
    always @(negedge CLK) begin
        if (!RES) begin
            bcnt = 0;
        end else if (BUSY) begin
            bcnt++;
        end else if (bcnt != 0) begin
            checks++;
            if (lat_q.size() == 0) begin
                errors++;
                $display("FAIL busy_unexpected got=%0d cycles", bcnt);
            end else begin
                int e;
                e = lat_q.pop_front();
                if (bcnt != e) begin
                    errors++;
                    $display("FAIL busy_len got=%0d want=%0d", bcnt, e);
                end
            end
            bcnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        CS = 1'b0; WR = 1'b0; AB_L = a; DB_IN = d;
        @(posedge CLK); #1;
        last_wr_cyc = cyc;
        CS = 1'b1; WR = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [8:0] exp);
        @(posedge CLK); #1;
        CS = 1'b0; RD = 1'b0; AB_L = a;
        rd_q.push_back(exp);
        @(posedge CLK); #1;
        CS = 1'b1; RD = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 100) begin
            @(posedge CLK);
            n++;
        end
        #1;
        if (BUSY) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout got=1 want=0");
        end
    endtask

    task automatic read_result(input logic [15:0] q, input logic [15:0] r);
        rd(3'd2, {1'b1, q[7:0]});
        rd(3'd3, {1'b1, q[15:8]});
        rd(3'd4, {1'b1, r[7:0]});
        rd(3'd5, {1'b1, r[15:8]});
    endtask

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        wr(3'd2, a[7:0]);
        wr(3'd3, a[15:8]);
        wr(3'd4, b[7:0]);
    endtask

    task automatic div_run(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] q, input logic [15:0] r);
        load_ops(a, b);
        lat_q.push_back(16);
        wr(3'd5, b[15:8]);
        wait_idle();
        read_result(q, r);
    endtask

    initial begin
        int start_cyc;
        logic [15:0] a, b, q, r;
        RES = 1'b0; CS = 1'b1; WR = 1'b1; RD = 1'b1; AB_L = 3'd0; DB_IN = 8'h00;
        repeat (3) @(posedge CLK);
        #1 RES = 1'b1;

        // Reset state
        check("busy_after_reset", {31'd0, BUSY}, 32'd0);
        read_result(16'h0000, 16'h0000);
        rd(3'd0, 9'h000);
        rd(3'd6, 9'h000);

        // Directed vectors
        div_run(16'd1000, 16'd7, 16'd142, 16'd6);
        div_run(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
        div_run(16'h0005, 16'h000A, 16'h0000, 16'h0005);
        div_run(16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE);
        div_run(16'h1234, 16'h0000, 16'hFFFF, 16'h1234);

        // Ignored write addresses leave the operands alone
        wr(3'd0, 8'h55); wr(3'd1, 8'h55); wr(3'd6, 8'h55); wr(3'd7, 8'h55);
        div_run(16'd1000, 16'd7, 16'd142, 16'd6);

        // Restart mid-division: previous result stays readable while BUSY
        load_ops(16'd1000, 16'd7);
        lat_q.push_back(0);
        wr(3'd5, 8'h00);
        start_cyc = last_wr_cyc;
        repeat (4) @(posedge CLK);
        wr(3'd2, 8'h64);
        wr(3'd3, 8'h00);
        wr(3'd5, 8'h00);
        void'(lat_q.pop_back());
        lat_q.push_back(last_wr_cyc - start_cyc + 16);
        read_result(16'd142, 16'd6);
        check("busy_during_restart", {31'd0, BUSY}, 32'd1);
        wait_idle();
        read_result(16'd14, 16'd2);

        // Reset pulse at iteration 8
        load_ops(16'd1000, 16'd7);
        wr(3'd5, 8'h00);
        repeat (8) @(posedge CLK);
        #2 RES = 1'b0;
        #1 check("busy_async_reset", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        #1 RES = 1'b1;
        repeat (20) @(posedge CLK);
        #1 check("busy_after_abort", {31'd0, BUSY}, 32'd0);
        read_result(16'h0000, 16'h0000);
        rd(3'd1, 9'h000);
        rd(3'd7, 9'h000);
        div_run(16'd1000, 16'd7, 16'd142, 16'd6);

        // WR held low for 3 clocks on address 5 must start exactly once
        load_ops(16'd5000, 16'd3);
        lat_q.push_back(16);
        @(posedge CLK); #1;
        CS = 1'b0; WR = 1'b0; AB_L = 3'd5; DB_IN = 8'h00;
        repeat (3) @(posedge CLK);
        #1 CS = 1'b1; WR = 1'b1;
        wait_idle();
        read_result(16'd1666, 16'd2);

        // Randomised sweep against the arithmetic reference
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 15));
                1:       b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            q = (b == 16'd0) ? 16'hFFFF : a / b;
            r = (b == 16'd0) ? a : a % b;
            div_run(a, b, q, r);
        end

        repeat (5) @(posedge CLK);
        check("queues_drained", 32'(rd_q.size() + lat_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
